// File: rtl/rpn_stack_engine_pkg.sv
// rpn_pkg: shared token codes, error codes and sequencer states for the
// RPN stack engine. Macro DIV_EN adds the DIV_WAIT state (token 0xE = DIV).
package rpn_pkg;

  // Keypad token codes (0x0-0x9 are digits)
  localparam logic [3:0] TOK_ADD   = 4'hA;
  localparam logic [3:0] TOK_SUB   = 4'hB;
  localparam logic [3:0] TOK_MUL   = 4'hC;
  localparam logic [3:0] TOK_ENTER = 4'hD;
  localparam logic [3:0] TOK_DROP  = 4'hE;
  localparam logic [3:0] TOK_DIV   = 4'hE;
  localparam logic [3:0] TOK_CLEAR = 4'hF;

  // Error codes shown to the display controller
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_FULL  = 2'd2;
  localparam logic [1:0] ERR_ARITH = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PUSH = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3
`ifdef DIV_EN
    , ST_DIV_WAIT = 3'd4
`endif
  } state_t;

  function automatic logic is_digit(input logic [3:0] t);
    return (t <= 4'd9);
  endfunction

endpackage

// File: rtl/rpn_stack_engine_if.sv
// Token handshake between the keypad decoder (master) and the engine (slave).
interface rpn_stack_engine_if;
  logic       tok_valid;
  logic [3:0] token;
  logic       tok_ready;

  modport master (output tok_valid, output token, input tok_ready);
  modport slave  (input tok_valid, input token, output tok_ready);
endinterface

// File: rtl/rpn_stack_engine_divider.sv
// stack_divider: restoring serial unsigned divider, one quotient bit per
// cycle. The first bit is produced on the start cycle, so done pulses
// exactly WIDTH cycles after start. Only compiled when DIV_EN is defined.
`ifdef DIV_EN
module stack_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] src_rem;
  logic [WIDTH-1:0] src_quo;
  logic [WIDTH-1:0] nxt_rem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;

  // One restoring step, taken from fresh operands on start
  always_comb begin
    if (start) begin
      src_rem = {WIDTH{1'b0}};
      src_quo = dividend;
    end else begin
      src_rem = rem;
      src_quo = quo;
    end
    shifted = {src_rem, src_quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      q_bit   = 1'b1;
      nxt_rem = trial[WIDTH-1:0];
    end else begin
      q_bit   = 1'b0;
      nxt_rem = shifted[WIDTH-1:0];
    end
  end

  // Iteration registers and the completion pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem  <= {WIDTH{1'b0}};
      quo  <= {WIDTH{1'b0}};
      cnt  <= {CW{1'b0}};
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= nxt_rem;
        quo <= {src_quo[WIDTH-2:0], q_bit};
        cnt <= CW'(WIDTH - 1);
      end else if (cnt != {CW{1'b0}}) begin
        rem  <= nxt_rem;
        quo  <= {src_quo[WIDTH-2:0], q_bit};
        cnt  <= cnt - CW'(1);
        done <= (cnt == CW'(1));
      end
    end
  end

  assign quotient = quo;
endmodule
`endif

// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: builds decimal operands from keypad tokens and runs RPN
// operators on a DEPTH x WIDTH stack. Define DIV_EN to turn token 0xE into
// an unsigned DIV via stack_divider (DROP is then unavailable).
module rpn_stack_engine
  import rpn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  rpn_stack_engine_if.slave   tok_if,
  output logic [WIDTH-1:0]    disp_val,
  output logic [DW-1:0]       depth,
  output logic                entry_active,
  output logic [1:0]          err,
  output logic                busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] SP_ZERO = DW'(0);
  localparam logic [DW-1:0] SP_TWO  = DW'(2);
  localparam logic [DW-1:0] SP_FULL = DW'(DEPTH);
`ifdef DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [DW-1:0]    sp;
  logic [WIDTH-1:0] entry;
  logic [3:0]       op;
  logic [WIDTH-1:0] result;
  logic [3:0]       tok;
  logic             accept;
  logic [AW-1:0]    idx_top;
  logic [AW-1:0]    idx_nos;
  logic [AW-1:0]    idx_push;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] push_val;
  logic [WIDTH+3:0] dig_val;
  logic             div_zero;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;

  function automatic logic is_op(input logic [3:0] t);
    return (t == TOK_ADD) || (t == TOK_SUB) || (t == TOK_MUL) || (DIV_ON && (t == TOK_DIV));
  endfunction

  assign tok             = tok_if.token;
  assign tok_if.tok_ready = (state == ST_IDLE);
  assign accept          = tok_if.tok_valid && (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign depth           = sp;

  assign idx_top  = AW'(sp - DW'(1));
  assign idx_nos  = AW'(sp - DW'(2));
  assign idx_push = AW'(sp);
  assign opa      = stack[idx_nos];
  assign opb      = stack[idx_top];
  assign push_val = entry_active ? entry : stack[idx_top];
  assign dig_val  = ({4'b0000, entry} * (WIDTH + 4)'(4'd10)) + (WIDTH + 4)'(tok);
  assign div_zero = DIV_ON && (op == TOK_DIV) && (opb == {WIDTH{1'b0}});
  assign disp_val = entry_active ? entry :
                    ((sp != SP_ZERO) ? stack[idx_top] : {WIDTH{1'b0}});

`ifdef DIV_EN
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;

  stack_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (opa),
    .divisor  (opb),
    .quotient (div_quo),
    .done     (div_done)
  );
`endif

  // Arithmetic on the two top entries; carries/high product bits flag err 3
  always_comb begin
    sum     = {1'b0, opa} + {1'b0, opb};
    prod    = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
    alu_res = {WIDTH{1'b0}};
    alu_err = 1'b0;
    case (op)
      TOK_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_err = sum[WIDTH];
      end
      TOK_SUB: begin
        alu_res = opa - opb;
        alu_err = 1'b0;
      end
      TOK_MUL: begin
        alu_res = prod[WIDTH-1:0];
        alu_err = |prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        alu_res = {WIDTH{1'b0}};
        alu_err = 1'b0;
      end
    endcase
  end

  // Sequencer state register; reset abandons any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection for the token sequencer
  always_comb begin
    next_state = state;
`ifdef DIV_EN
    div_start = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!accept) begin
          next_state = ST_IDLE;
        end else if (tok == TOK_ENTER) begin
          next_state = (entry_active || (sp != SP_ZERO)) ? ST_PUSH : ST_IDLE;
        end else if (is_op(tok)) begin
          next_state = entry_active ? ST_PUSH : ST_EXEC;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_PUSH: next_state = (is_op(op) && (sp != SP_FULL)) ? ST_EXEC : ST_IDLE;
      ST_EXEC: begin
        if ((sp < SP_TWO) || div_zero) begin
          next_state = ST_IDLE;
`ifdef DIV_EN
        end else if (op == TOK_DIV) begin
          div_start  = 1'b1;
          next_state = ST_DIV_WAIT;
`endif
        end else begin
          next_state = ST_WB;
        end
      end
`ifdef DIV_EN
      ST_DIV_WAIT: next_state = div_done ? ST_WB : ST_DIV_WAIT;
`endif
      ST_WB:   next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Stack pointer, operand entry, pending operator, result and error code
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp           <= SP_ZERO;
      entry        <= {WIDTH{1'b0}};
      entry_active <= 1'b0;
      err          <= ERR_NONE;
      op           <= 4'h0;
      result       <= {WIDTH{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op  <= tok;
            err <= ERR_NONE;
            if (is_digit(tok)) begin
              entry        <= dig_val[WIDTH-1:0];
              entry_active <= 1'b1;
              if (dig_val[WIDTH+3:WIDTH] != 4'h0) begin
                err <= ERR_ARITH;
              end
            end else if (tok == TOK_CLEAR) begin
              sp           <= SP_ZERO;
              entry        <= {WIDTH{1'b0}};
              entry_active <= 1'b0;
            end else if (tok == TOK_ENTER) begin
              if (!entry_active && (sp == SP_ZERO)) begin
                err <= ERR_UNDER;
              end
            end else if (!DIV_ON && (tok == TOK_DROP)) begin
              if (entry_active) begin
                entry        <= {WIDTH{1'b0}};
                entry_active <= 1'b0;
              end else if (sp != SP_ZERO) begin
                sp <= sp - DW'(1);
              end else begin
                err <= ERR_UNDER;
              end
            end
          end
        end
        ST_PUSH: begin
          entry        <= {WIDTH{1'b0}};
          entry_active <= 1'b0;
          if (sp == SP_FULL) begin
            err <= ERR_FULL;
          end else begin
            sp <= sp + DW'(1);
          end
        end
        ST_EXEC: begin
          if (sp < SP_TWO) begin
            err <= ERR_UNDER;
          end else if (div_zero) begin
            err <= ERR_ARITH;
          end else begin
            result <= alu_res;
            if (alu_err) begin
              err <= ERR_ARITH;
            end
          end
        end
`ifdef DIV_EN
        ST_DIV_WAIT: begin
          if (div_done) begin
            result <= div_quo;
          end
        end
`endif
        ST_WB: sp <= sp - DW'(1);
        default: sp <= sp;
      endcase
    end
  end

  // Stack storage: push in PUSH, collapse the top two entries in WB
  always_ff @(posedge clk) begin
    if ((state == ST_PUSH) && (sp != SP_FULL)) begin
      stack[idx_push] <= push_val;
    end else if (state == ST_WB) begin
      stack[idx_nos] <= result;
    end
  end

endmodule
